lockstep_mem_initiator: RTL

Initiator side of the single-port synchronous word memory interface (en/we/address/data_in/data_out, 1-cycle registered read). It accepts duplicated memory requests from the two lockstep cores (A and B) and compares them. A matching request is issued to memory exactly once, and the response is returned to both cores. A mismatch, or excessive skew between the two cores, raises a sticky lockstep error and blocks all memory access.

---
 rtl/lockstep_mem_initiator.sv | 121 ++++++++++++
 1 files changed

// File: rtl/lockstep_mem_initiator.sv
// Lockstep memory initiator: compares duplicated requests from cores A and B and
// issues one memory access per matching pair; a mismatch or excess skew locks the port.
module lockstep_mem_initiator #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int SKEW_MAX = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid_a,
    input  logic              req_we_a,
    input  logic [ADDR_W-1:0] req_addr_a,
    input  logic [DATA_W-1:0] req_wdata_a,
    input  logic              req_valid_b,
    input  logic              req_we_b,
    input  logic [ADDR_W-1:0] req_addr_b,
    input  logic [DATA_W-1:0] req_wdata_b,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    input  logic              rsp_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              lockstep_err,
    input  logic              err_clear
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ISSUE   = 3'd1;
    localparam logic [2:0] WAIT_RD = 3'd2;
    localparam logic [2:0] RESP    = 3'd3;
    localparam logic [2:0] ERROR   = 3'd4;

    localparam int CNT_W = (SKEW_MAX < 1) ? 1 : $clog2(SKEW_MAX + 1);
    localparam logic [CNT_W-1:0] SKEW_LIM = CNT_W'(SKEW_MAX);

    logic [2:0]       state, state_nxt;
    logic             running;
    logic [CNT_W-1:0] skew_cnt, skew_cnt_nxt;
    logic             skew_side, skew_side_nxt;
    logic             cap_we;
    logic             both_valid, one_valid, fields_match, accept;

    assign both_valid   = req_valid_a & req_valid_b;
    assign one_valid    = req_valid_a ^ req_valid_b;
    assign fields_match = (req_we_a == req_we_b) && (req_addr_a == req_addr_b) &&
                          (!req_we_a || (req_wdata_a == req_wdata_b));

    // Skew counts consecutive cycles in which the same core is alone; a change
    // of lone core restarts the run at one.
    always_comb begin
        state_nxt     = state;
        skew_cnt_nxt  = '0;
        skew_side_nxt = skew_side;
        accept        = 1'b0;
        case (state)
            IDLE: begin
                if (running) begin
                    if (both_valid) begin
                        if (fields_match) begin
                            accept    = 1'b1;
                            state_nxt = ISSUE;
                        end else begin
                            state_nxt = ERROR;
                        end
                    end else if (one_valid) begin
                        skew_side_nxt = req_valid_b;
                        if ((skew_cnt != '0) && (skew_side != req_valid_b)) begin
                            skew_cnt_nxt = CNT_W'(1);
                        end else if (skew_cnt >= SKEW_LIM) begin
                            state_nxt = ERROR;
                        end else begin
                            skew_cnt_nxt = skew_cnt + 1'b1;
                        end
                    end
                end
            end
            ISSUE:   state_nxt = cap_we ? RESP : WAIT_RD;
            WAIT_RD: state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            ERROR:   if (err_clear) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            running   <= 1'b0;
            skew_cnt  <= '0;
            skew_side <= 1'b0;
            cap_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rsp_rdata <= '0;
        end else begin
            state     <= state_nxt;
            running   <= 1'b1;
            skew_cnt  <= skew_cnt_nxt;
            skew_side <= skew_side_nxt;
            if (accept) begin
                cap_we    <= req_we_a;
                mem_addr  <= req_addr_a;
                mem_wdata <= req_wdata_a;
            end
            if ((state == ISSUE) && cap_we) rsp_rdata <= '0;
            if (state == WAIT_RD)           rsp_rdata <= mem_rdata;
        end
    end

    // running keeps req_ready low while reset is held even though state is IDLE.
    assign req_ready    = running && (state == IDLE);
    assign mem_en       = (state == ISSUE);
    assign mem_we       = (state == ISSUE) && cap_we;
    assign rsp_valid    = (state == RESP);
    assign lockstep_err = (state == ERROR);

endmodule
